// File: rtl/burst_bus_adapter.sv
// burst_bus_adapter
//   Turns one L2 line request (read or write, LINE_WIDTH bits) into a burst of
//   32-bit OBI transactions on the same line, then returns the assembled line
//   for reads. Word addresses only wrap within the line. Granted transactions
//   that still await rvalid are capped at MAX_OUTSTANDING.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mem_req_valid_i/ready_o       line request handshake
//   mem_req_rw_i                  1 = write
//   mem_req_addr_i                line address
//   mem_req_byteen_i/data_i       write byte enables / write data
//   mem_req_tag_i                 request tag, echoed on the read response
//   mem_rsp_valid_o/ready_i       read line handshake
//   mem_rsp_data_o/tag_o          assembled read line and its tag
//   obi_req_o/gnt_i               OBI address phase handshake
//   obi_addr_o/we_o/be_o/wdata_o  OBI address phase payload
//   obi_rvalid_i/rdata_i          OBI response phase (in order)
module burst_bus_adapter #(
    parameter int LINE_WIDTH        = 512,
    parameter int ADDR_WIDTH        = 26,
    parameter int TAG_WIDTH         = 8,
    parameter int MAX_OUTSTANDING   = 2,
    parameter int SKIP_EMPTY_WRITES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mem_req_valid_i,
    output logic                    mem_req_ready_o,
    input  logic                    mem_req_rw_i,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr_i,
    input  logic [LINE_WIDTH/8-1:0] mem_req_byteen_i,
    input  logic [LINE_WIDTH-1:0]   mem_req_data_i,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag_i,
    output logic                    mem_rsp_valid_o,
    input  logic                    mem_rsp_ready_i,
    output logic [LINE_WIDTH-1:0]   mem_rsp_data_o,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [31:0]             obi_addr_o,
    output logic                    obi_we_o,
    output logic [3:0]              obi_be_o,
    output logic [31:0]             obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [31:0]             obi_rdata_i
);

    localparam int WORDS = LINE_WIDTH / 32;
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH/8-1:0] byteen_q;
    logic [LINE_WIDTH-1:0]   data_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    logic [IDX_W-1:0]        rcv_idx_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    accept;
    logic                    grant;
    logic                    rsp_in;
    logic                    store;
    logic [IDX_W:0]          nxt;

    // Words that need an OBI transaction: every word of a read, and for a
    // write only words with at least one byte enabled (when skipping is on).
    function automatic logic [WORDS-1:0] issue_mask(input logic rw,
                                                    input logic [LINE_WIDTH/8-1:0] be);
        logic [WORDS-1:0] m;
        m = '0;
        for (int i = 0; i < WORDS; i++) begin
            m[i] = !(rw && (SKIP_EMPTY_WRITES != 0)) || (|be[4*i +: 4]);
        end
        return m;
    endfunction

    // Lowest set bit of mask at or above start; MSB of the result = found.
    function automatic logic [IDX_W:0] find_next(input logic [WORDS-1:0] mask,
                                                 input logic [IDX_W:0]   start);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (!found && (i >= int'(start)) && mask[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        return {found, idx};
    endfunction

    assign mem_req_ready_o = (state_q == IDLE) && (cnt_q == '0);
    assign accept          = mem_req_valid_i && mem_req_ready_o;

    // The registered count gates the request, so a grant can never push the
    // count past the limit even when an rvalid arrives in the same cycle.
    assign obi_req_o = (state_q == ISSUE) && (cnt_q != CNT_MAX);
    assign grant     = obi_req_o && obi_gnt_i;
    assign rsp_in    = obi_rvalid_i && (cnt_q != '0);
    assign store     = rsp_in && !rw_q && ((state_q == ISSUE) || (state_q == WAIT));

    // Byte address = {line_addr, word_idx, 2'b00}, truncated to 32 bits.
    assign obi_addr_o  = (32'(addr_q) << (IDX_W + 2)) | (32'(word_idx_q) << 2);
    assign obi_we_o    = rw_q;
    assign obi_be_o    = rw_q ? byteen_q[{word_idx_q, 2'b00} +: 4] : 4'hF;
    assign obi_wdata_o = rw_q ? data_q[{word_idx_q, 5'b00000} +: 32] : 32'h0;

    assign mem_rsp_valid_o = (state_q == RESP);
    assign mem_rsp_data_o  = line_q;
    assign mem_rsp_tag_o   = tag_q;

    always_comb begin
        cnt_d = cnt_q;
        if (grant && !rsp_in) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!grant && rsp_in) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        nxt        = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Jump straight to the first issuable word; a write with
                    // nothing enabled never leaves IDLE.
                    nxt = find_next(issue_mask(mem_req_rw_i, mem_req_byteen_i), '0);
                    if (nxt[IDX_W]) begin
                        state_d    = ISSUE;
                        word_idx_d = nxt[IDX_W-1:0];
                    end else begin
                        word_idx_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (grant) begin
                    nxt = find_next(issue_mask(rw_q, byteen_q), {1'b0, word_idx_q} + 1'b1);
                    if (nxt[IDX_W]) begin
                        word_idx_d = nxt[IDX_W-1:0];
                    end else begin
                        word_idx_d = '0;
                        state_d    = rw_q ? IDLE : WAIT;
                    end
                end
            end
            WAIT: begin
                if (rsp_in && (rcv_idx_q == IDX_W'(WORDS - 1))) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            rcv_idx_q  <= '0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            byteen_q   <= '0;
            data_q     <= '0;
            tag_q      <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            cnt_q      <= cnt_d;
            if (accept) begin
                rw_q      <= mem_req_rw_i;
                addr_q    <= mem_req_addr_i;
                byteen_q  <= mem_req_byteen_i;
                data_q    <= mem_req_data_i;
                tag_q     <= mem_req_tag_i;
                rcv_idx_q <= '0;
            end else if (store) begin
                // OBI responses come back in order: n-th rvalid is word n.
                line_q[{rcv_idx_q, 5'b00000} +: 32] <= obi_rdata_i;
                rcv_idx_q                           <= rcv_idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_burst_bus_adapter.sv
module tb_burst_bus_adapter;

    localparam int LW   = 512;
    localparam int AW   = 26;
    localparam int TW   = 8;
    localparam int MAXO = 2;
    localparam int NW   = LW / 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_rw;
    logic [AW-1:0]   mem_req_addr;
    logic [LW/8-1:0] mem_req_byteen;
    logic [LW-1:0]   mem_req_data;
    logic [TW-1:0]   mem_req_tag;
    logic            mem_rsp_valid;
    logic            mem_rsp_ready;
    logic [LW-1:0]   mem_rsp_data;
    logic [TW-1:0]   mem_rsp_tag;
    logic            obi_req;
    logic            obi_gnt = 1'b0;
    logic [31:0]     obi_addr;
    logic            obi_we;
    logic [3:0]      obi_be;
    logic [31:0]     obi_wdata;
    logic            obi_rvalid = 1'b0;
    logic [31:0]     obi_rdata = 32'h0;

    burst_bus_adapter #(
        .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .MAX_OUTSTANDING(MAXO), .SKIP_EMPTY_WRITES(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_valid_i(mem_req_valid), .mem_req_ready_o(mem_req_ready),
        .mem_req_rw_i(mem_req_rw), .mem_req_addr_i(mem_req_addr),
        .mem_req_byteen_i(mem_req_byteen), .mem_req_data_i(mem_req_data),
        .mem_req_tag_i(mem_req_tag),
        .mem_rsp_valid_o(mem_rsp_valid), .mem_rsp_ready_i(mem_rsp_ready),
        .mem_rsp_data_o(mem_rsp_data), .mem_rsp_tag_o(mem_rsp_tag),
        .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr),
        .obi_we_o(obi_we), .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // ---------------- OBI slave model ----------------
    int          gnt_dly = 0;
    int          rv_lat  = 1;
    logic [31:0] rd_base = 32'h0;
    int          txn_base = 0;

    logic [31:0] log_addr[$];
    logic [36:0] log_pl[$];     // {we, be, wdata}
    int          log_cyc[$];
    int          due_q[$];
    logic [31:0] rdq[$];
    int          wait_cnt = 0;
    int          outs = 0;
    int          max_err = 0;
    int          stab_err = 0;
    logic        held = 1'b0;
    logic [68:0] held_pl = '0;

    always @(negedge clk) begin
        outs = due_q.size();
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            obi_rvalid = 1'b1;
            obi_rdata  = rdq[0];
            void'(due_q.pop_front());
            void'(rdq.pop_front());
        end else begin
            obi_rvalid = 1'b0;
            obi_rdata  = 32'hBAD0_0000 | 32'(cyc);
        end
        if (held && (!obi_req || {obi_addr, obi_we, obi_be, obi_wdata} != held_pl))
            stab_err++;
        if (obi_req) begin
            if (wait_cnt >= gnt_dly) begin
                obi_gnt  = 1'b1;
                wait_cnt = 0;
                held     = 1'b0;
                if (outs >= MAXO) max_err++;
                log_addr.push_back(obi_addr);
                log_pl.push_back({obi_we, obi_be, obi_wdata});
                log_cyc.push_back(cyc);
                due_q.push_back(cyc + rv_lat);
                rdq.push_back(rd_base + 32'(log_addr.size() - 1 - txn_base));
            end else begin
                obi_gnt  = 1'b0;
                wait_cnt++;
                held     = 1'b1;
                held_pl  = {obi_addr, obi_we, obi_be, obi_wdata};
            end
        end else begin
            obi_gnt  = 1'b0;
            wait_cnt = 0;
            held     = 1'b0;
        end
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        bit            rw;
        logic [AW-1:0] addr;
        logic [63:0]   be;
        logic [TW-1:0] tag;
        int            gdly;
        int            lat;
        int            stall;
        logic [31:0]   rbase;
        int            exp_n;
        logic [31:0]   exp_first;
        logic [31:0]   exp_last;
        int            exp_rsp_lat;
        bit            exp_rdy_next;
    } vec_t;

    task automatic run_vec(input string nm, input vec_t v);
        int            base, acc, rsp_cyc, t, n, k, hold_err, rsp_seen;
        logic [LW-1:0] snap_d;
        logic [TW-1:0] snap_t;
        gnt_dly = v.gdly;
        rv_lat  = v.lat;
        rd_base = v.rbase;
        @(negedge clk); #1;
        base     = log_addr.size();
        txn_base = base;
        mem_req_rw     = v.rw;
        mem_req_addr   = v.addr;
        mem_req_byteen = v.be;
        mem_req_tag    = v.tag;
        for (int w = 0; w < NW; w++) mem_req_data[w*32 +: 32] = 32'hC0DE_0000 + 32'(w);
        mem_req_valid = 1'b1;
        t = 0;
        while (!mem_req_ready && t < 100) begin @(negedge clk); #1; t++; end
        check({nm, ".accept"}, 64'(mem_req_ready), 64'd1);
        acc = cyc;
        @(negedge clk); #1;
        mem_req_valid = 1'b0;
        check({nm, ".ready_next"}, 64'(mem_req_ready), 64'(v.exp_rdy_next));
        rsp_seen = 0;
        if (!v.rw) begin
            t = 0;
            while (!mem_rsp_valid && t < 500) begin @(negedge clk); #1; t++; end
            check({nm, ".rsp_valid"}, 64'(mem_rsp_valid), 64'd1);
            rsp_cyc = cyc;
            if (v.exp_rsp_lat != 0) begin
                check({nm, ".rsp_latency"}, 64'(rsp_cyc - acc), 64'(v.exp_rsp_lat));
                if (log_cyc.size() >= base + NW) begin
                    check({nm, ".first_gnt_cyc"}, 64'(log_cyc[base] - acc), 64'd1);
                    check({nm, ".last_gnt_cyc"}, 64'(log_cyc[base+NW-1] - acc), 64'd16);
                end
            end
            snap_d   = mem_rsp_data;
            snap_t   = mem_rsp_tag;
            hold_err = 0;
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk); #1;
                if (!mem_rsp_valid || mem_rsp_data != snap_d || mem_rsp_tag != snap_t || mem_req_ready)
                    hold_err++;
            end
            if (v.stall > 0) check({nm, ".rsp_hold"}, 64'(hold_err), 64'd0);
            check({nm, ".tag"}, 64'(mem_rsp_tag), 64'(v.tag));
            for (int w = 0; w < NW; w++)
                check($sformatf("%s.word%0d", nm, w), 64'(mem_rsp_data[w*32 +: 32]), 64'(v.rbase + 32'(w)));
            mem_rsp_ready = 1'b1;
            @(negedge clk); #1;
            mem_rsp_ready = 1'b0;
            check({nm, ".rsp_done"}, 64'({mem_rsp_valid, mem_req_ready}), 64'b01);
        end else begin
            t = 0;
            while ((due_q.size() != 0 || !mem_req_ready) && t < 500) begin
                if (mem_rsp_valid) rsp_seen++;
                @(negedge clk); #1;
                t++;
            end
            check({nm, ".drained"}, 64'(mem_req_ready), 64'd1);
            check({nm, ".no_rsp"}, 64'(rsp_seen), 64'd0);
        end
        n = log_addr.size() - base;
        check({nm, ".n_txn"}, 64'(n), 64'(v.exp_n));
        if (n > 0) begin
            check({nm, ".first_addr"}, 64'(log_addr[base]), 64'(v.exp_first));
            check({nm, ".last_addr"}, 64'(log_addr[base+n-1]), 64'(v.exp_last));
        end
        k = 0;
        for (int w = 0; w < NW; w++) begin
            if (!v.rw || v.be[w*4 +: 4] != 4'h0) begin
                if (k < n) begin
                    check($sformatf("%s.t%0d_addr", nm, k),
                          64'({log_addr[base+k][31:6], log_addr[base+k][5:0]}),
                          64'({v.exp_first[31:6], 6'(w*4)}));
                    check($sformatf("%s.t%0d_pl", nm, k), 64'(log_pl[base+k]),
                          v.rw ? 64'({1'b1, v.be[w*4 +: 4], 32'hC0DE_0000 + 32'(w)})
                               : 64'({1'b0, 4'hF, 32'h0}));
                end
                k++;
            end
        end
    endtask

    vec_t  tbl[6];
    string nm[6];
    vec_t  rv;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t, late_err;
        tbl[0] = '{1'b0, 26'h100, 64'h0, 8'h5A, 0, 1, 0, 32'hA0, 16, 32'h4000, 32'h403C, 18, 1'b0};
        tbl[1] = '{1'b1, 26'h100, 64'h0000_0030_0000_F000, 8'h11, 0, 1, 0, 32'h0, 2, 32'h400C, 32'h4024, 0, 1'b0};
        tbl[2] = '{1'b0, 26'h3, 64'h0, 8'h33, 3, 4, 0, 32'h1000, 16, 32'hC0, 32'hFC, 0, 1'b0};
        tbl[3] = '{1'b0, 26'h3FF_FFFF, 64'h0, 8'hC3, 0, 2, 10, 32'h5000_0000, 16, 32'hFFFF_FFC0, 32'hFFFF_FFFC, 0, 1'b0};
        tbl[4] = '{1'b1, 26'h200, 64'h0, 8'h44, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1'b1};
        tbl[5] = '{1'b1, 26'h20, {64{1'b1}}, 8'h55, 1, 3, 0, 32'h0, 16, 32'h800, 32'h83C, 0, 1'b0};
        nm[0] = "rd_basic"; nm[1] = "wr_sparse"; nm[2] = "rd_slow";
        nm[3] = "rd_stall"; nm[4] = "wr_empty";  nm[5] = "wr_full";

        rst_n = 1'b0;
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0;
        mem_req_byteen = '0; mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.ready", 64'(mem_req_ready), 64'd1);
        check("reset.obi_req", 64'(obi_req), 64'd0);
        check("reset.rsp_valid", 64'(mem_rsp_valid), 64'd0);
        check("reset.rsp_data", 64'(|mem_rsp_data), 64'd0);
        check("reset.rsp_tag", 64'(mem_rsp_tag), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(nm[i], tbl[i]);

        // Reset in the middle of a read burst.
        gnt_dly = 0; rv_lat = 4; rd_base = 32'h7700;
        @(negedge clk); #1;
        base = log_addr.size(); txn_base = base;
        mem_req_rw = 1'b0; mem_req_addr = 26'h40; mem_req_tag = 8'h66; mem_req_valid = 1'b1;
        @(negedge clk); #1;
        mem_req_valid = 1'b0;
        t = 0;
        while (log_addr.size() - base < 5 && t < 200) begin @(negedge clk); #1; t++; end
        check("rst_mid.five_grants", 64'(log_addr.size() - base), 64'd5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid.obi_req_low", 64'(obi_req), 64'd0);
        check("rst_mid.rsp_valid_low", 64'(mem_rsp_valid), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid.ready_after", 64'(mem_req_ready), 64'd1);
        late_err = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (mem_rsp_valid || !mem_req_ready || obi_req) late_err++;
        end
        check("rst_mid.late_rvalid_ignored", 64'(late_err), 64'd0);
        rv = '{1'b0, 26'h40, 64'h0, 8'h77, 0, 1, 0, 32'h9900, 16, 32'h1000, 32'h103C, 18, 1'b0};
        run_vec("rd_after_rst", rv);

        check("max_outstanding", 64'(max_err), 64'd0);
        check("payload_stable", 64'(stab_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/burst_bus_adapter.md
BURST_BUS_ADAPTER -- requirements
Module: burst_bus_adapter

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 512: L2 memory line width in bits; power of two, multiple of 32, at least 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26: line-address width; byte address = {line_addr, word_idx, 2'b00}, truncated to 32 bits.
REQ-003 SHALL have parameter TAG_WIDTH, default 8: memory-request tag width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, range 1..8: maximum granted OBI transactions awaiting rvalid.
REQ-005 SHALL have parameter SKIP_EMPTY_WRITES, default 1: when 1, write words whose 4-bit byte enable is zero are not issued.
REQ-006 SHALL have ports (WORDS = LINE_WIDTH/32):
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset; one clock, reset asynchronous and active-low.
- mem_req_valid_i, in, 1, line request valid.
- mem_req_ready_o, out, 1, line request accepted.
- mem_req_rw_i, in, 1, 1 = write.
- mem_req_addr_i, in, ADDR_WIDTH, line address.
- mem_req_byteen_i, in, LINE_WIDTH/8, write byte enables.
- mem_req_data_i, in, LINE_WIDTH, write data.
- mem_req_tag_i, in, TAG_WIDTH, request tag.
- mem_rsp_valid_o, out, 1, read line valid.
- mem_rsp_ready_i, in, 1, read line consumed.
- mem_rsp_data_o, out, LINE_WIDTH, read line.
- mem_rsp_tag_o, out, TAG_WIDTH, tag of read.
- obi_req_o, out, 1, OBI request.
- obi_gnt_i, in, 1, OBI grant.
- obi_addr_o, out, 32, byte address.
- obi_we_o, out, 1, write enable.
- obi_be_o, out, 4, byte enables.
- obi_wdata_o, out, 32, write data.
- obi_rvalid_i, in, 1, OBI response valid.
- obi_rdata_i, in, 32, read data.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-008 SHALL drive mem_req_ready_o = 1 only in IDLE with outstanding count 0; on valid&ready SHALL latch rw, addr, byteen, data, tag, set word_idx = 0, and go to ISSUE.
REQ-009 SHALL, in ISSUE, assert obi_req_o with addr/we/be/wdata of word word_idx (word 0 = bits 31:0), for reads be = 4'hF and wdata = 0.
REQ-010 SHALL hold obi_req_o and all OBI payload stable until obi_gnt_i; on grant SHALL advance to the next issuable word in the following cycle, allowing back-to-back grants.
REQ-011 SHALL keep obi_req_o low while the registered outstanding count equals MAX_OUTSTANDING; count += grant, -= rvalid, both in the same cycle net to zero change.
REQ-012 SHALL, for writes with SKIP_EMPTY_WRITES = 1, skip words with be = 0 without an OBI transaction; a write with all byteen zero SHALL return to IDLE the cycle after acceptance with no OBI activity.
REQ-013 SHALL, for writes, go IDLE after the last word is granted; write rvalids SHALL decrement the count, their rdata SHALL be discarded, and no mem response SHALL be generated.
REQ-014 SHALL, for reads, store the n-th rvalid rdata into line word n (OBI in-order); ISSUE -> WAIT after word WORDS-1 granted; WAIT -> RESP when the WORDS-th rvalid arrives.
REQ-015 SHALL, in RESP, assert mem_rsp_valid_o with the assembled line and latched tag, holding stable until mem_rsp_ready_i; then go IDLE.
REQ-016 SHALL, with gnt held high and rvalid one cycle after grant, for LINE_WIDTH = 512: accept at cycle 0, grants cycles 1..16, rvalids 2..17, mem_rsp_valid_o at cycle 18.
REQ-017 SHALL ignore obi_rvalid_i when the outstanding count is 0, with no underflow.
REQ-018 SHALL wrap word address only within the line; line_addr never increments.

Reset
REQ-019 SHALL, while rst_ni low, force state IDLE, count 0, word_idx 0, obi_req_o 0, mem_rsp_valid_o 0, mem_req_ready_o 1, line buffer, data and tag outputs 0.
REQ-020 SHALL, on reset mid-transaction, abandon the line immediately with no response, and SHALL accept a new request on the first cycle after rst_ni rises.

Verification
REQ-021 Read, addr 0x100, gnt always 1, rvalid +1 cycle, rdata = 0xA0+n -> OBI addrs 0x4000..0x403C, rsp at cycle 18, data words 0xA0..0xAF, tag echoed.
REQ-022 Write, byteen only on words 3 and 9 (0xF, 0x3) -> exactly two OBI writes, addrs base+0x0C, base+0x24, be 0xF and 0x3; no mem response.
REQ-023 Read with gnt delayed 3 cycles and rvalid latency 4, MAX_OUTSTANDING = 2 -> never more than 2 ungranted-response transactions; payload stable while req&!gnt; line correct.
REQ-024 Read rsp with mem_rsp_ready_i low 10 cycles -> valid, data, tag held; mem_req_ready_o stays 0 until handshake.
REQ-025 Reset pulse after 5 of 16 read grants -> obi_req_o 0 immediately; no mem_rsp_valid_o; late rvalids ignored; next read completes correctly.
REQ-026 All-zero-byteen write -> mem_req_ready_o back to 1 one cycle after acceptance, obi_req_o never asserted.
